// File: rtl/medidor_frequencia.sv
// medidor_frequencia: counts rising edges of an asynchronous signal over a
// fixed gate window. The result is an 8-bit value that saturates at 255 and
// feeds the 3-digit 7-segment display driver.
module medidor_frequencia #(
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       sinal,
    output logic [7:0] numero,
    output logic       pronto,
    output logic       estouro,
    output logic       medindo
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        MEDINDO  = 2'd1,
        ATUALIZA = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic              sync_a;
    logic              sync_b;
    logic              sinal_prev;
    logic              edge_det;
    logic [GATE_W-1:0] gate_cnt;
    logic              gate_last;
    logic [7:0]        edge_cnt;
    logic              overflow;
    logic [7:0]        cnt_next;
    logic              ovf_next;
    logic              medindo_next;
    logic              pronto_next;

    // Saturating increment: holds at 255 once the count is full.
    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic inc);
        if (inc && (val != 8'hFF)) begin
            return val + 8'd1;
        end
        return val;
    endfunction

    // Overflow sets when an edge arrives while the count is already full.
    function automatic logic ovf_update(input logic [7:0] val, input logic inc,
                                        input logic ovf);
        return ovf | (inc & (val == 8'hFF));
    endfunction

    // Two-flop synchronizer plus previous-value register; runs in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            sinal_prev <= 1'b0;
        end else begin
            sync_a     <= sinal;
            sync_b     <= sync_a;
            sinal_prev <= sync_b;
        end
    end

    assign edge_det  = sync_b & ~sinal_prev;
    assign gate_last = (gate_cnt == GATE_LAST);
    assign cnt_next  = sat_inc(edge_cnt, edge_det);
    assign ovf_next  = ovf_update(edge_cnt, edge_det, overflow);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OCIOSO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping habilita aborts even on the final gate cycle.
    always_comb begin
        next_state = state;
        case (state)
            OCIOSO: begin
                if (habilita) next_state = MEDINDO;
            end
            MEDINDO: begin
                if (!habilita)      next_state = OCIOSO;
                else if (gate_last) next_state = ATUALIZA;
            end
            ATUALIZA: begin
                next_state = habilita ? MEDINDO : OCIOSO;
            end
            default: next_state = OCIOSO;
        endcase
    end

    // Output decode, evaluated one cycle ahead so the outputs can be registered.
    always_comb begin
        medindo_next = (next_state == MEDINDO);
        pronto_next  = (next_state == ATUALIZA);
    end

    // Gate and edge counters: cleared outside MEDINDO so every window starts at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            overflow <= 1'b0;
        end else if (state == MEDINDO) begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= cnt_next;
            overflow <= ovf_next;
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            overflow <= 1'b0;
        end
    end

    // Registered outputs; the result is latched on the same edge that enters ATUALIZA,
    // including any edge detected in the final gate cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            numero  <= 8'd0;
            estouro <= 1'b0;
            pronto  <= 1'b0;
            medindo <= 1'b0;
        end else begin
            medindo <= medindo_next;
            pronto  <= pronto_next;
            if (pronto_next) begin
                numero  <= cnt_next;
                estouro <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_medidor_frequencia.sv
// Testbench for medidor_frequencia: two instances (short and long gate) driven by
// the same stimulus and compared every cycle against a behavioural model.
module tb_medidor_frequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b0;
    logic       sinal = 1'b0;
    logic [7:0] numero_s, numero_b;
    logic       pronto_s, pronto_b;
    logic       estouro_s, estouro_b;
    logic       medindo_s, medindo_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    medidor_frequencia #(.GATE_CYCLES(100), .GATE_W(8)) dut_s (
        .clock(clock), .reset(reset), .habilita(habilita), .sinal(sinal),
        .numero(numero_s), .pronto(pronto_s), .estouro(estouro_s), .medindo(medindo_s)
    );

    medidor_frequencia #(.GATE_CYCLES(600), .GATE_W(10)) dut_b (
        .clock(clock), .reset(reset), .habilita(habilita), .sinal(sinal),
        .numero(numero_b), .pronto(pronto_b), .estouro(estouro_b), .medindo(medindo_b)
    );

    // Reference model. pos: -1 idle, 0..G-1 inside the window, G = update cycle.
    int gate[2] = '{100, 600};
    int pos[2]  = '{-1, -1};
    int cnt[2]  = '{0, 0};
    int num[2]  = '{0, 0};
    int est[2]  = '{0, 0};
    int prn[2]  = '{0, 0};
    // Sinal history as seen by the detector: d1 = one cycle ago, d2 = two, d3 = three.
    int d1 = 0, d2 = 0, d3 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic h, input logic s, input logic r);
        int e;
        e = (d2 == 1 && d3 == 0) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                pos[i] = -1; cnt[i] = 0; num[i] = 0; est[i] = 0; prn[i] = 0;
            end else begin
                prn[i] = 0;
                if (pos[i] == -1) begin
                    if (h) begin pos[i] = 0; cnt[i] = 0; end
                end else if (pos[i] == gate[i]) begin
                    pos[i] = h ? 0 : -1;
                    cnt[i] = 0;
                end else if (!h) begin
                    pos[i] = -1;
                end else begin
                    cnt[i] += e;
                    if (pos[i] == gate[i] - 1) begin
                        pos[i] = gate[i];
                        num[i] = (cnt[i] > 255) ? 255 : cnt[i];
                        est[i] = (cnt[i] > 255) ? 1 : 0;
                        prn[i] = 1;
                    end else begin
                        pos[i]++;
                    end
                end
            end
        end
        if (r) begin
            d1 = 0; d2 = 0; d3 = 0;
        end else begin
            d3 = d2; d2 = d1; d1 = int'(s);
        end
    endtask

    task automatic tick(input logic h, input logic s, input logic r);
        habilita = h;
        sinal    = s;
        reset    = r;
        model_step(h, s, r);
        @(posedge clock);
        #1;
        check("s_numero",  numero_s,  num[0]);
        check("s_pronto",  pronto_s,  prn[0]);
        check("s_estouro", estouro_s, est[0]);
        check("s_medindo", medindo_s, (pos[0] >= 0 && pos[0] < gate[0]) ? 1 : 0);
        check("b_numero",  numero_b,  num[1]);
        check("b_pronto",  pronto_b,  prn[1]);
        check("b_estouro", estouro_b, est[1]);
        check("b_medindo", medindo_b, (pos[1] >= 0 && pos[1] < gate[1]) ? 1 : 0);
    endtask

    function automatic logic sq10(input int k);
        return (k >= 5) && (((k - 5) % 10) < 5);
    endfunction

    initial begin
        logic h;
        logic s;
        int   run;

        // Reset, then continuous measurement of a period-10 square wave.
        tick(0, 0, 1);
        tick(0, 0, 1);
        check("rst_numero", numero_s, 0);
        check("rst_medindo", medindo_s, 0);
        for (int k = 0; k <= 352; k++) begin
            tick(1, sq10(k), 0);
            if (k == 0)   check("win1_medindo_c1", medindo_s, 1);
            if (k == 99)  check("win1_medindo_c100", medindo_s, 1);
            if (k == 100) begin
                check("win1_pronto", pronto_s, 1);
                check("win1_numero", numero_s, 10);
                check("win1_estouro", estouro_s, 0);
                check("win1_medindo_c101", medindo_s, 0);
            end
            if (k == 101) check("win1_pronto_off", pronto_s, 0);
            if (k == 201) begin
                check("win2_pronto", pronto_s, 1);
                check("win2_numero", numero_s, 10);
            end
        end

        // Abort at cycle 50 of a window, then re-raise habilita.
        tick(0, sq10(353), 0);
        check("abort_medindo", medindo_s, 0);
        check("abort_numero", numero_s, 10);
        for (int k = 354; k < 374; k++) begin
            tick(0, sq10(k), 0);
            check("abort_no_pronto", pronto_s, 0);
        end
        for (int k = 374; k < 414; k++) tick(1, sq10(k), 0);

        // One-cycle reset in the middle of a window.
        tick(1, sq10(414), 1);
        check("midrst_numero", numero_s, 0);
        check("midrst_pronto", pronto_s, 0);
        check("midrst_estouro", estouro_s, 0);
        check("midrst_medindo", medindo_s, 0);

        // Long gate: period 2 saturates, then period 4 gives 150.
        tick(0, 0, 1);
        tick(0, 0, 1);
        for (int k = 0; k <= 1201; k++) begin
            s = (k < 600) ? logic'(k % 2) : logic'((k % 4) >= 2);
            tick(1, s, 0);
            if (k == 600) begin
                check("sat_pronto", pronto_b, 1);
                check("sat_numero", numero_b, 255);
                check("sat_estouro", estouro_b, 1);
            end
            if (k == 1201) begin
                check("p4_pronto", pronto_b, 1);
                check("p4_numero", numero_b, 150);
                check("p4_estouro", estouro_b, 0);
            end
        end

        // Sinal held high for a whole window, then a single one-cycle pulse.
        tick(0, 1, 1);
        tick(0, 1, 1);
        for (int k = 0; k < 5; k++) tick(0, 1, 0);
        for (int k = 0; k <= 201; k++) begin
            tick(1, (k < 101) || (k == 150), 0);
            if (k == 100) check("held_numero", numero_s, 0);
            if (k == 201) check("pulse_numero", numero_s, 1);
        end

        // Randomized traffic: random pulse widths, occasional aborts and resets.
        h = 1'b1;
        s = 1'b0;
        run = 1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 149) == 0) h = ~h;
            run--;
            if (run <= 0) begin
                s = ~s;
                run = int'($urandom_range(1, 8));
            end
            tick(h, s, $urandom_range(0, 399) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/medidor_frequencia.md
Name: medidor_frequencia

Overview:
- Upstream feeder of the 3-digit multiplexed 7-segment display driver.
- Counts rising edges of an asynchronous external signal over a fixed gate window, e.g. a tone or beat pulse from the spectrum front-end.
- Presents the result as a stable 8-bit binary value `numero`, saturated at 255. The display path converts `numero` to BCD and shows it.
- Value updates once per window; a one-cycle strobe marks each update.

Parameters:
- GATE_CYCLES, 50000000: clock cycles per measurement window (1 s at 50 MHz). Must be >= 2.
- GATE_W, 26: width of the gate counter. Must satisfy 2^GATE_W > GATE_CYCLES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- habilita  input  1  measurement enable; level-sensitive.
- sinal  input  1  asynchronous external signal to measure.
- numero  output  8  last completed measurement, saturated at 255; feeds the display driver.
- pronto  output  1  one-cycle pulse, high in the cycle `numero` holds a new value.
- estouro  output  1  high if the last completed window exceeded 255 edges.
- medindo  output  1  high while a window is open (state MEDINDO).

Behaviour:
- All outputs are registered.
- Reset (synchronous, checked on every clock edge, priority over everything, effective mid-window) clears:
  - state to OCIOSO;
  - both synchronizer flops and the edge-detect register;
  - gate counter and edge counter;
  - numero=0, pronto=0, estouro=0, medindo=0.
- Input path:
  - 2-flop synchronizer on `sinal`, then a previous-value register.
  - Edge detected when sync output=1 and previous=0.
  - Latency from a `sinal` rise to the edge being counted: 3 clocks.
  - The detect registers run in all states. Only edges detected while in MEDINDO are counted.
- Edge counter:
  - 8-bit, saturating: holds at 255.
  - An internal overflow flag sets when an edge arrives while the count is 255.
- FSM OCIOSO: medindo=0.
  - habilita=1 -> MEDINDO; gate counter, edge counter and overflow flag cleared.
  - Otherwise stay; numero and estouro hold.
- FSM MEDINDO: medindo=1.
  - Gate counter increments every cycle.
  - habilita=0 -> OCIOSO (abort): no pronto; numero and estouro retain previous values; partial count discarded.
  - Gate counter == GATE_CYCLES-1 -> ATUALIZA. An edge detected in that last cycle is counted.
  - A window is therefore exactly GATE_CYCLES cycles.
- FSM ATUALIZA: medindo=0.
  - Single cycle.
  - numero <= edge count; estouro <= overflow flag; pronto=1 in this same cycle, coincident with the new numero.
  - Edges detected in this cycle are not counted (one dead cycle).
  - Next: habilita=1 -> MEDINDO with counters cleared; otherwise OCIOSO.
  - Back-to-back period: GATE_CYCLES+1 cycles.
- pronto is never high for two consecutive cycles.
- numero changes only in ATUALIZA or on reset.
- `sinal` held constant, or a single rise before the window opens, yields a count of 0.
- A `sinal` high pulse of >= 1 clock that meets setup/hold is counted once.
- Pulses narrower than a clock period may be missed; this is accepted.
- Simultaneous habilita=0 and the final gate cycle: abort wins (-> OCIOSO, no pronto).

Test Plan (GATE_CYCLES=100, GATE_W=8 unless stated):
- Reset, then habilita=1 from cycle 0; `sinal` square wave, period 10, first rise at cycle 5:
  - pronto once at cycle 101;
  - numero=10, estouro=0;
  - medindo high cycles 1-100.
- Continue habilita=1:
  - pronto repeats every 101 cycles;
  - numero stays 10;
  - dead-cycle edge not counted (place a rise so it is detected in the ATUALIZA cycle; next window still reads 9 or 10 as computed).
- GATE_CYCLES=600, GATE_W=10, `sinal` period 2 (300 rises): numero=255, estouro=1. Next window at period 4 (150 rises): numero=150, estouro=0.
- After a completed window (numero=10), drop habilita at cycle 50 of the next window:
  - medindo=0 next cycle;
  - no pronto;
  - numero stays 10;
  - re-raise habilita: new window starts from count 0.
- Assert reset for one cycle mid-window: the following cycle numero=0, estouro=0, pronto=0, medindo=0, state OCIOSO.
- `sinal` held 1 for the whole window: numero=0. A single 1-cycle-wide high pulse inside the window: numero=1.
